riscv_instr_encoder: RTL
========================

// Module: riscv_instr_encoder
// PURPOSE
// - Inverse of the core's control decode: turns an op id (6-bit, `instr.vh` macros ADD..JALR, NOPE) plus rd/rs1/rs2/imm into a 32-bit RV32I word.
// - Two-stage valid/ready pipeline. Feeds BIOS/test-program generators and the instruction-injection path of the testbench harness.
// PARAMETERS
// - CNT_W  16  width of the emitted-instruction counter (wraps)
// PORTS
// - clk          in   1      clock, all state on rising edge
// - rst          in   1      asynchronous, active-high reset
// - flush        in   1      synchronous; drops both pipeline stages
// - in_valid     in   1      request valid
// - in_ready     out  1      encoder accepts request this cycle
// - in_op        in   6      op id per `instr.vh`
// - in_rd        in   5      destination register
// - in_rs1       in   5      source register 1
// - in_rs2       in   5      source register 2
// - in_imm       in   32     byte immediate, signed (LUI/AUIPC: upper 20 bits in imm[19:0])
// - out_valid    out  1      encoded word valid
// - out_ready    in   1      consumer accepts word
// - out_instr    out  32     encoded instruction
// - out_illegal  out  1      in_op not a legal id; out_instr = 32'h00000013
// - out_range_err out 1      immediate out of field range (see CONFIGURATION)
// - out_count    out  CNT_W  words handed off (out_valid & out_ready), wraps
// BEHAVIOUR
// - Reset: out_valid=0, in_ready=1, out_instr=0, out_illegal=0, out_range_err=0, out_count=0, both stage valids 0.
// - S1 registers request + format class (R/I/SHIFT/LOAD/S/B/U/J/JALR/ILL); S2 registers assembled word.
// - Latency 2 cycles, in_valid&in_ready at edge N -> out_valid at N+2 (out_ready held 1); throughput 1/cycle.
// - Stage advances when its downstream slot is empty or being consumed; in_ready = !s1_v | (s1 moves).
// - out_valid=0 when stalled empty; out_instr/flags hold stable while out_valid & !out_ready.
// - Field rules: opcode/funct3 per opcode.vh; SUB/SRA/SRAI set bit30; shifts use imm[4:0], bits31:25 forced 0 except bit30.
// - S: imm[11:5]->[31:25], imm[4:0]->[11:7]. B: imm[12|10:5]->[31:25], imm[4:1|11]->[11:7]; imm[0] ignored.
// - U: imm[19:0]->[31:12]. J: imm[20|10:1|11|19:12]->[31:12]; imm[0] ignored.
// - Unused register fields forced to 0 (e.g. rs2 for I-type, rs1/rs2 for U/J).
// - NOPE or undefined id: out_instr=32'h00000013, out_illegal=1 for undefined only (NOPE is legal, illegal=0).
// - flush: s1_v,s2_v cleared next edge; flush and in_valid same cycle -> request dropped, in_ready=1.
// - out_count increments once per handoff; CNT_W-bit wrap (max -> 0); flush does not clear it.
// - rst asserted mid-stream: all in-flight words discarded immediately, no partial handoff.
// CONFIGURATION
// - ENCODER_RANGE_CHECK_EN defined: out_range_err=1 with the word when imm does not fit:
//   I/LOAD/S/JALR -2048..2047; shift 0..31; B even, -4096..4094; J even, -1048576..1048574;
//   U imm[31:20] must be 0. Word still emitted with truncated imm.
// - Not defined: no checker logic, out_range_err tied 0.
// TESTING
// - ADDI rd=1 rs1=0 imm=5 -> 32'h00500093, illegal=0, latency 2 cycles.
// - ADD rd=3 rs1=1 rs2=2 then SUB same regs back-to-back -> 32'h002081B3, 32'h402081B3, consecutive cycles.
// - SW rs1=1 rs2=2 imm=8 -> 32'h0020A423; BEQ rs1=1 rs2=2 imm=8 -> 32'h00208463.
// - LUI rd=5 imm=20'h12345 -> 32'h123452B7; JAL rd=1 imm=16 -> 32'h010000EF.
// - out_ready=0 for 5 cycles with 3 requests queued -> in_ready drops after 2 held, out_instr stable, all 3 delivered in order, out_count=3.
// - Undefined op id -> 32'h00000013 with out_illegal=1; with ENCODER_RANGE_CHECK_EN, ADDI imm=4096 -> out_range_err=1; flush mid-stream -> no out_valid next 2 cycles.

Source files
------------

// File: rtl/riscv_instr_encoder.sv
// Two-stage valid/ready RV32I encoder: op id + register/immediate fields -> 32-bit word.
// Optional immediate range checker enabled by defining ENCODER_RANGE_CHECK_EN.
module riscv_instr_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_illegal,
  output logic             out_range_err,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [5:0] OP_ADD  = 6'd0,  OP_SUB  = 6'd1,  OP_SLL  = 6'd2,  OP_SLT   = 6'd3;
  localparam logic [5:0] OP_SLTU = 6'd4,  OP_XOR  = 6'd5,  OP_SRL  = 6'd6,  OP_SRA   = 6'd7;
  localparam logic [5:0] OP_OR   = 6'd8,  OP_AND  = 6'd9,  OP_ADDI = 6'd10, OP_SLTI  = 6'd11;
  localparam logic [5:0] OP_SLTIU= 6'd12, OP_XORI = 6'd13, OP_ORI  = 6'd14, OP_ANDI  = 6'd15;
  localparam logic [5:0] OP_SLLI = 6'd16, OP_SRLI = 6'd17, OP_SRAI = 6'd18, OP_LB    = 6'd19;
  localparam logic [5:0] OP_LH   = 6'd20, OP_LW   = 6'd21, OP_LBU  = 6'd22, OP_LHU   = 6'd23;
  localparam logic [5:0] OP_SB   = 6'd24, OP_SH   = 6'd25, OP_SW   = 6'd26, OP_BEQ   = 6'd27;
  localparam logic [5:0] OP_BNE  = 6'd28, OP_BLT  = 6'd29, OP_BGE  = 6'd30, OP_BLTU  = 6'd31;
  localparam logic [5:0] OP_BGEU = 6'd32, OP_LUI  = 6'd33, OP_AUIPC= 6'd34, OP_JAL   = 6'd35;
  localparam logic [5:0] OP_JALR = 6'd36, OP_NOPE = 6'd37;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [3:0] {
    FMT_R, FMT_I, FMT_SHIFT, FMT_LOAD, FMT_S, FMT_B, FMT_U, FMT_J, FMT_JALR, FMT_NOP, FMT_ILL
  } fmt_t;

  fmt_t        dec_fmt, s1_fmt;
  logic [2:0]  dec_f3, s1_f3;
  logic [6:0]  dec_opc, s1_opc;
  logic        dec_b30, s1_b30;
  logic        s1_v, s2_v;
  logic [4:0]  s1_rd, s1_rs1, s1_rs2;
  logic [31:0] s1_imm;
  logic [31:0] asm_word;
  logic        asm_illegal, asm_rerr;
  logic        s2_ready, accept;

  assign s2_ready  = !s2_v || out_ready;
  assign in_ready  = flush || !s1_v || s2_ready;
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = s2_v;

  // Op id -> format class, funct3, opcode, bit30
  always_comb begin
    dec_fmt = FMT_ILL;
    dec_f3  = 3'd0;
    dec_b30 = 1'b0;
    dec_opc = 7'b0010011;
    case (in_op)
      OP_ADD:   dec_fmt = FMT_R;
      OP_SUB:   begin dec_fmt = FMT_R; dec_b30 = 1'b1; end
      OP_SLL:   begin dec_fmt = FMT_R; dec_f3 = 3'd1; end
      OP_SLT:   begin dec_fmt = FMT_R; dec_f3 = 3'd2; end
      OP_SLTU:  begin dec_fmt = FMT_R; dec_f3 = 3'd3; end
      OP_XOR:   begin dec_fmt = FMT_R; dec_f3 = 3'd4; end
      OP_SRL:   begin dec_fmt = FMT_R; dec_f3 = 3'd5; end
      OP_SRA:   begin dec_fmt = FMT_R; dec_f3 = 3'd5; dec_b30 = 1'b1; end
      OP_OR:    begin dec_fmt = FMT_R; dec_f3 = 3'd6; end
      OP_AND:   begin dec_fmt = FMT_R; dec_f3 = 3'd7; end
      OP_ADDI:  dec_fmt = FMT_I;
      OP_SLTI:  begin dec_fmt = FMT_I; dec_f3 = 3'd2; end
      OP_SLTIU: begin dec_fmt = FMT_I; dec_f3 = 3'd3; end
      OP_XORI:  begin dec_fmt = FMT_I; dec_f3 = 3'd4; end
      OP_ORI:   begin dec_fmt = FMT_I; dec_f3 = 3'd6; end
      OP_ANDI:  begin dec_fmt = FMT_I; dec_f3 = 3'd7; end
      OP_SLLI:  begin dec_fmt = FMT_SHIFT; dec_f3 = 3'd1; end
      OP_SRLI:  begin dec_fmt = FMT_SHIFT; dec_f3 = 3'd5; end
      OP_SRAI:  begin dec_fmt = FMT_SHIFT; dec_f3 = 3'd5; dec_b30 = 1'b1; end
      OP_LB:    dec_fmt = FMT_LOAD;
      OP_LH:    begin dec_fmt = FMT_LOAD; dec_f3 = 3'd1; end
      OP_LW:    begin dec_fmt = FMT_LOAD; dec_f3 = 3'd2; end
      OP_LBU:   begin dec_fmt = FMT_LOAD; dec_f3 = 3'd4; end
      OP_LHU:   begin dec_fmt = FMT_LOAD; dec_f3 = 3'd5; end
      OP_SB:    dec_fmt = FMT_S;
      OP_SH:    begin dec_fmt = FMT_S; dec_f3 = 3'd1; end
      OP_SW:    begin dec_fmt = FMT_S; dec_f3 = 3'd2; end
      OP_BEQ:   dec_fmt = FMT_B;
      OP_BNE:   begin dec_fmt = FMT_B; dec_f3 = 3'd1; end
      OP_BLT:   begin dec_fmt = FMT_B; dec_f3 = 3'd4; end
      OP_BGE:   begin dec_fmt = FMT_B; dec_f3 = 3'd5; end
      OP_BLTU:  begin dec_fmt = FMT_B; dec_f3 = 3'd6; end
      OP_BGEU:  begin dec_fmt = FMT_B; dec_f3 = 3'd7; end
      OP_LUI:   dec_fmt = FMT_U;
      OP_AUIPC: dec_fmt = FMT_U;
      OP_JAL:   dec_fmt = FMT_J;
      OP_JALR:  dec_fmt = FMT_JALR;
      OP_NOPE:  dec_fmt = FMT_NOP;
      default:  dec_fmt = FMT_ILL;
    endcase
    case (dec_fmt)
      FMT_R:    dec_opc = 7'b0110011;
      FMT_LOAD: dec_opc = 7'b0000011;
      FMT_S:    dec_opc = 7'b0100011;
      FMT_B:    dec_opc = 7'b1100011;
      FMT_U:    dec_opc = (in_op == OP_LUI) ? 7'b0110111 : 7'b0010111;
      FMT_J:    dec_opc = 7'b1101111;
      FMT_JALR: dec_opc = 7'b1100111;
      default:  dec_opc = 7'b0010011;
    endcase
  end

  // Field placement from the registered request
  always_comb begin
    asm_word    = NOP_WORD;
    asm_illegal = 1'b0;
    case (s1_fmt)
      FMT_R:     asm_word = {1'b0, s1_b30, 5'd0, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_opc};
      FMT_I, FMT_LOAD, FMT_JALR:
                 asm_word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_opc};
      FMT_SHIFT: asm_word = {1'b0, s1_b30, 5'd0, s1_imm[4:0], s1_rs1, s1_f3, s1_rd, s1_opc};
      FMT_S:     asm_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_opc};
      FMT_B:     asm_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                             s1_imm[4:1], s1_imm[11], s1_opc};
      FMT_U:     asm_word = {s1_imm[19:0], s1_rd, s1_opc};
      FMT_J:     asm_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opc};
      FMT_NOP:   asm_word = NOP_WORD;
      default:   asm_illegal = 1'b1;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  // Immediate must be representable in the field it is packed into
  always_comb begin
    asm_rerr = 1'b0;
    case (s1_fmt)
      FMT_I, FMT_LOAD, FMT_S, FMT_JALR: asm_rerr = (s1_imm[31:11] != {21{s1_imm[11]}});
      FMT_SHIFT: asm_rerr = |s1_imm[31:5];
      FMT_B:     asm_rerr = s1_imm[0] || (s1_imm[31:12] != {20{s1_imm[12]}});
      FMT_U:     asm_rerr = |s1_imm[31:20];
      FMT_J:     asm_rerr = s1_imm[0] || (s1_imm[31:20] != {12{s1_imm[20]}});
      default:   asm_rerr = 1'b0;
    endcase
  end
`else
  logic unused_imm_hi;
  assign asm_rerr      = 1'b0;
  assign unused_imm_hi = ^s1_imm[31:21];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v          <= 1'b0;
      s1_fmt        <= FMT_NOP;
      s1_f3         <= 3'd0;
      s1_opc        <= 7'd0;
      s1_b30        <= 1'b0;
      s1_rd         <= 5'd0;
      s1_rs1        <= 5'd0;
      s1_rs2        <= 5'd0;
      s1_imm        <= 32'd0;
      s2_v          <= 1'b0;
      out_instr     <= 32'd0;
      out_illegal   <= 1'b0;
      out_range_err <= 1'b0;
      out_count     <= '0;
    end else begin
      if (s2_v && out_ready) out_count <= out_count + CNT_W'(1);
      if (flush) begin
        s1_v <= 1'b0;
        s2_v <= 1'b0;
      end else begin
        if (in_ready) s1_v <= in_valid;
        if (accept) begin
          s1_fmt <= dec_fmt;
          s1_f3  <= dec_f3;
          s1_opc <= dec_opc;
          s1_b30 <= dec_b30;
          s1_rd  <= in_rd;
          s1_rs1 <= in_rs1;
          s1_rs2 <= in_rs2;
          s1_imm <= in_imm;
        end
        if (s2_ready) begin
          s2_v <= s1_v;
          if (s1_v) begin
            out_instr     <= asm_word;
            out_illegal   <= asm_illegal;
            out_range_err <= asm_rerr;
          end
        end
      end
    end
  end

endmodule
